// File: rtl/led_zone_mean.sv
// led_zone_mean: accumulates one RGB888 frame into 8 vertical zones and
// publishes per-zone 4-bit means with a one-cycle start pulse.
// Optional build macro: LED_MEAN_ROUND_EN (round-to-nearest, saturating mean
// instead of truncation).
module led_zone_mean #(
    parameter int unsigned ZONE_W_LOG2 = 6,
    parameter int unsigned V_ACT_LOG2  = 9
) (
    input  logic       clk_slow,
    input  logic       rstn,
    input  logic       en,
    input  logic       pix_sof,
    input  logic       pix_valid,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic [3:0] MeanR [7:0],
    output logic [3:0] MeanG [7:0],
    output logic [3:0] MeanB [7:0],
    output logic       start,
    output logic       busy
);

    localparam int unsigned N_ZONE = 8;
    localparam int unsigned COL_W  = ZONE_W_LOG2 + 3;
    localparam int unsigned SHIFT  = ZONE_W_LOG2 + V_ACT_LOG2;
    localparam int unsigned ACC_W  = 8 + SHIFT;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

`ifdef LED_MEAN_ROUND_EN
    localparam logic [8:0] ROUND_ADD = 9'd8;
`else
    localparam logic [8:0] ROUND_ADD = 9'd0;
`endif

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  load_c;
    logic                  add_c;
    logic                  last_px_c;
    logic [2:0]            zone_c;
    logic [COL_W-1:0]      col;
    logic [V_ACT_LOG2-1:0] line;
    logic [ACC_W-1:0]      acc_r [N_ZONE];
    logic [ACC_W-1:0]      acc_g [N_ZONE];
    logic [ACC_W-1:0]      acc_b [N_ZONE];

    // Zone sum -> 4-bit mean; with ROUND_ADD=0 this reduces to avg8[7:4].
    function automatic logic [3:0] zone_mean(input logic [ACC_W-1:0] acc);
        logic [7:0] avg8;
        logic [8:0] sum;
        avg8 = 8'(acc >> SHIFT);
        sum  = 9'(avg8) + ROUND_ADD;
        if (sum > 9'd255) begin
            return 4'hF;
        end
        return 4'(sum >> 4);
    endfunction

    assign zone_c    = col[COL_W-1 -: 3];
    assign last_px_c = (&col) && (&line);

    // Next-state and datapath control; an SOF in ACC aborts the running frame.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        add_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pix_valid && pix_sof && en) begin
                    load_c    = 1'b1;
                    state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (pix_valid) begin
                    if (pix_sof) begin
                        if (en) begin
                            load_c = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        add_c = 1'b1;
                        if (last_px_c) begin
                            state_nxt = S_LATCH;
                        end
                    end
                end
            end
            S_LATCH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks ACC/LATCH exactly.
    always_ff @(posedge clk_slow or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Position counters and zone accumulators; SOF reloads zone 0 and clears the rest.
    always_ff @(posedge clk_slow or negedge rstn) begin
        if (!rstn) begin
            col  <= '0;
            line <= '0;
            for (int k = 0; k < N_ZONE; k++) begin
                acc_r[k] <= '0;
                acc_g[k] <= '0;
                acc_b[k] <= '0;
            end
        end else if (load_c) begin
            col  <= COL_W'(1);
            line <= '0;
            for (int k = 1; k < N_ZONE; k++) begin
                acc_r[k] <= '0;
                acc_g[k] <= '0;
                acc_b[k] <= '0;
            end
            acc_r[0] <= ACC_W'(pix_r);
            acc_g[0] <= ACC_W'(pix_g);
            acc_b[0] <= ACC_W'(pix_b);
        end else if (add_c) begin
            col <= col + COL_W'(1);
            if (&col) begin
                line <= line + V_ACT_LOG2'(1);
            end
            acc_r[zone_c] <= acc_r[zone_c] + ACC_W'(pix_r);
            acc_g[zone_c] <= acc_g[zone_c] + ACC_W'(pix_g);
            acc_b[zone_c] <= acc_b[zone_c] + ACC_W'(pix_b);
        end
    end

    // Mean outputs latched in LATCH, start pulses in the same cycle they appear.
    always_ff @(posedge clk_slow or negedge rstn) begin
        if (!rstn) begin
            start <= 1'b0;
            for (int k = 0; k < N_ZONE; k++) begin
                MeanR[k] <= '0;
                MeanG[k] <= '0;
                MeanB[k] <= '0;
            end
        end else begin
            start <= (state == S_LATCH);
            if (state == S_LATCH) begin
                for (int k = 0; k < N_ZONE; k++) begin
                    MeanR[k] <= zone_mean(acc_r[k]);
                    MeanG[k] <= zone_mean(acc_g[k]);
                    MeanB[k] <= zone_mean(acc_b[k]);
                end
            end
        end
    end

endmodule
